// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings, FSM states and helpers for the EX-stage multiply/divide unit
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MFHI  = 3'd5,
        MD_MFLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2
    } md_state_e;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mf(input logic [2:0] op);
        return (op == MD_MFHI) || (op == MD_MFLO);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - unsigned iterative datapath: shift-add multiply, restoring divide
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             last,
    output logic [WIDTH-1:0] hi_raw,
    output logic [WIDTH-1:0] lo_raw
);

    localparam int CW = $clog2(WIDTH);

    // acc:q is one 2*WIDTH shift register; m is the multiplicand or divisor
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]    count;
    logic             mode;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] sub;
    logic             fits;

    always_comb begin
        add_sum = {1'b0, acc} + (q[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        shifted = {acc, q[WIDTH-1]};
        sub     = shifted[WIDTH-1:0] - m;
        fits    = shifted[WIDTH] || (shifted[WIDTH-1:0] >= m);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            q     <= '0;
            m     <= '0;
            count <= '0;
            mode  <= 1'b0;
        end else if (start) begin
            acc   <= '0;
            q     <= op_a;
            m     <= op_b;
            count <= '0;
            mode  <= div_mode;
        end else if (step) begin
            count <= count + CW'(1);
            if (!mode) begin
                acc <= add_sum[WIDTH:1];
                q   <= {add_sum[0], q[WIDTH-1:1]};
            end else if (fits) begin
                acc <= sub;
                q   <= {q[WIDTH-2:0], 1'b1};
            end else begin
                acc <= shifted[WIDTH-1:0];
                q   <= {q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign last   = step && (count == CW'(WIDTH-1));
    assign hi_raw = acc;
    assign lo_raw = q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - EX-stage multiply/divide unit owning HI/LO, with pipeline stall
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             stall_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    md_state_e        state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_mode_r;
    logic             div_zero;
    logic             neg_main;
    logic             neg_rem;

    logic             issue;
    logic             div_op;
    logic             b_zero;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    logic             core_last;
    logic [WIDTH-1:0] core_hi;
    logic [WIDTH-1:0] core_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    // A zero divisor loads the raw dividend so FIX can hand it straight to HI
    always_comb begin
        issue  = valid_i && is_muldiv(op_i);
        div_op = is_div_op(op_i);
        b_zero = (b_i == '0);
        a_neg  = is_signed_op(op_i) && a_i[WIDTH-1];
        b_neg  = is_signed_op(op_i) && b_i[WIDTH-1];
        core_a = (a_neg && !(div_op && b_zero)) ? -a_i : a_i;
        core_b = b_neg ? -b_i : b_i;
    end

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk_i),
        .rst      (rst_i),
        .start    ((state == S_IDLE) && issue),
        .step     (state == S_BUSY),
        .div_mode (div_op),
        .op_a     (core_a),
        .op_b     (core_b),
        .last     (core_last),
        .hi_raw   (core_hi),
        .lo_raw   (core_lo)
    );

    always_comb begin
        prod   = {core_hi, core_lo};
        fix_hi = core_hi;
        fix_lo = core_lo;
        if (div_zero) begin
            fix_hi = core_lo;
            fix_lo = '1;
        end else if (div_mode_r) begin
            fix_lo = neg_main ? -core_lo : core_lo;
            fix_hi = neg_rem  ? -core_hi : core_hi;
        end else begin
            prod   = neg_main ? -prod : prod;
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            hi         <= '0;
            lo         <= '0;
            div_mode_r <= 1'b0;
            div_zero   <= 1'b0;
            neg_main   <= 1'b0;
            neg_rem    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        div_mode_r <= div_op;
                        div_zero   <= div_op && b_zero;
                        neg_main   <= a_neg ^ b_neg;
                        neg_rem    <= a_neg;
                        state      <= (div_op && b_zero) ? S_FIX : S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (core_last) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // FIX itself never stalls; only a pending MFHI/MFLO holds the pipe there
    assign stall_o  = ((state == S_IDLE) && issue) || (state == S_BUSY) ||
                      (valid_i && is_mf(op_i) && (state != S_IDLE));
    assign busy_o   = (state != S_IDLE);
    assign result_o = (op_i == MD_MFHI) ? hi : ((op_i == MD_MFLO) ? lo : '0);
    assign hi_o     = hi;
    assign lo_o     = lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] result;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .valid_i  (valid),
        .op_i     (op),
        .a_i      (a),
        .b_i      (b),
        .result_o (result),
        .stall_o  (stall),
        .busy_o   (busy),
        .hi_o     (hi),
        .lo_o     (lo)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          stalls;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Architectural result {HI, LO} from plain integer arithmetic
    function automatic logic [63:0] model(input logic [2:0] mop, input logic [31:0] ma,
                                          input logic [31:0] mb);
        longint sa;
        longint sb;
        logic [63:0] r;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        case (mop)
            MD_MULT:  r = 64'(sa * sb);
            MD_MULTU: r = {32'b0, ma} * {32'b0, mb};
            MD_DIV:   r = (mb == 0) ? {ma, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            MD_DIVU:  r = (mb == 0) ? {ma, 32'hFFFF_FFFF} : {ma % mb, ma / mb};
            default:  r = '0;
        endcase
        return r;
    endfunction

    // Called at posedge+1 with the unit idle; returns at posedge+1 of the idle cycle after FIX
    task automatic run_op(input logic [2:0] rop, input logic [31:0] ra, input logic [31:0] rb,
                          output int n);
        valid = 1'b1;
        op    = rop;
        a     = ra;
        b     = rb;
        n     = 0;
        forever begin
            @(negedge clk);
            if (!stall || n >= 100) break;
            n++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        op    = MD_NONE;
    endtask

    initial begin
        int          n;
        logic [63:0] e;

        vecs[0] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
        vecs[1] = '{MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 33};
        vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[3] = '{MD_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         33};
        vecs[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33};
        vecs[5] = '{MD_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1};
        vecs[6] = '{MD_DIV,   32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF, 1};
        vecs[7] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33};
        vecs[8] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};

        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        valid = 1'b1;
        op    = MD_MFHI;
        #1;
        check("reset_stall", {31'b0, stall}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        valid = 1'b0;
        op    = MD_NONE;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
            check($sformatf("vec%0d_stalls", i), 32'(n), 32'(vecs[i].stalls));
            check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
            valid = 1'b1;
            op    = MD_MFLO;
            #1;
            check($sformatf("vec%0d_mflo", i), result, vecs[i].lo);
            check($sformatf("vec%0d_mf_stall", i), {31'b0, stall}, 32'd0);
            op = MD_MFHI;
            #1;
            check($sformatf("vec%0d_mfhi", i), result, vecs[i].hi);
            valid = 1'b0;
            op    = MD_NONE;
            @(posedge clk);
            #1;
        end

        // MFHI arriving behind a running MULTU waits until the unit is idle again
        e     = model(MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        valid = 1'b1;
        op    = MD_MULTU;
        a     = 32'h1234_5678;
        b     = 32'h9ABC_DEF0;
        n     = 0;
        @(negedge clk);
        if (stall) n++;
        @(posedge clk);
        #1;
        op = MD_MFHI;
        forever begin
            @(negedge clk);
            if (!stall || n >= 100) break;
            n++;
            @(posedge clk);
            #1;
        end
        check("mfhi_busy_stalls", 32'(n), 32'd34);
        check("mfhi_busy_result", result, e[63:32]);
        @(posedge clk);
        #1;
        valid = 1'b0;
        op    = MD_NONE;

        // Reset while BUSY with count=10
        valid = 1'b1;
        op    = MD_MULT;
        a     = 32'd1000;
        b     = 32'd3;
        repeat (11) @(posedge clk);
        #1;
        check("midop_busy", {31'b0, busy}, 32'd1);
        valid = 1'b0;
        op    = MD_NONE;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midop_rst_busy", {31'b0, busy}, 32'd0);
        check("midop_rst_stall", {31'b0, stall}, 32'd0);
        check("midop_rst_hi", hi, 32'd0);
        check("midop_rst_lo", lo, 32'd0);
        e = model(MD_MULT, 32'hFFFF_FF00, 32'd12345);
        run_op(MD_MULT, 32'hFFFF_FF00, 32'd12345, n);
        check("after_rst_stalls", 32'(n), 32'd33);
        check("after_rst_hi", hi, e[63:32]);
        check("after_rst_lo", lo, e[31:0]);

        // Randomised back-to-back ops against the arithmetic model
        for (int i = 0; i < 32; i++) begin
            logic [2:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            int          mode;
            rop  = 3'($urandom_range(1, 4));
            ra   = $urandom;
            rb   = $urandom;
            mode = $urandom_range(0, 7);
            if (mode == 0) rb = 32'd0;
            if (mode == 1) rb = 32'($urandom_range(1, 9));
            if (mode == 2) rb = -32'($urandom_range(1, 9));
            if (mode == 3) ra = 32'h8000_0000;
            if (mode == 4) ra = 32'($urandom_range(0, 100));
            e = model(rop, ra, rb);
            run_op(rop, ra, rb, n);
            check($sformatf("rand%0d_stalls op=%0d", i, rop), 32'(n),
                  (is_div_op(rop) && rb == 0) ? 32'd1 : 32'd33);
            check($sformatf("rand%0d_hi op=%0d a=%h b=%h", i, rop, ra, rb), hi, e[63:32]);
            check($sformatf("rand%0d_lo op=%0d a=%h b=%h", i, rop, ra, rb), lo, e[31:0]);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
